// File: rtl/banner_scroll_ctrl.sv
// banner_scroll_ctrl: fetches banner rows from a registered ROM and streams a
// WIN-pixel scrolling window of each row over a valid/ready handshake.
// Ports: clk, rst (sync, active high), start; rom_addr_o-style ROM side
// (rom_addr, rom_data); row stream (row_valid, row_ready, row_idx, row_pix);
// status (frame_done, busy, offset).
// Option: define BANNER_SCROLL_BIDIR_EN to add input dir (1 = scroll left).
module banner_scroll_ctrl #(
  parameter int ROWS       = 15,
  parameter int COLS       = 71,
  parameter int WIN        = 16,
  parameter int SCROLL_DIV = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic [4:0]      rom_addr,
  input  logic [COLS-1:0] rom_data,
  output logic            row_valid,
  input  logic            row_ready,
  output logic [4:0]      row_idx,
  output logic [WIN-1:0]  row_pix,
  output logic            frame_done,
  output logic            busy,
  output logic [6:0]      offset
`ifdef BANNER_SCROLL_BIDIR_EN
  ,
  input  logic            dir
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WAIT,
    OUT,
    DONE
  } state_e;

  localparam int FCW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
  localparam logic [FCW-1:0] FC_LAST = FCW'(SCROLL_DIV - 1);
  localparam logic [4:0]     R_LAST  = 5'(ROWS - 1);
  localparam logic [6:0]     C_LAST  = 7'(COLS - 1);

  state_e            state_q, state_d;
  logic [4:0]        r_q, r_d;
  logic [COLS-1:0]   buf_q, buf_d;
  logic [6:0]        off_q, off_d;
  logic [FCW-1:0]    fc_q, fc_d;
  logic [6:0]        off_step;

  always_comb begin
`ifdef BANNER_SCROLL_BIDIR_EN
    if (dir) begin
      off_step = (off_q == 7'd0) ? C_LAST : off_q - 7'd1;
    end else begin
      off_step = (off_q == C_LAST) ? 7'd0 : off_q + 7'd1;
    end
`else
    off_step = (off_q == C_LAST) ? 7'd0 : off_q + 7'd1;
`endif
  end

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    buf_d   = buf_q;
    off_d   = off_q;
    fc_d    = fc_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          r_d     = '0;
          state_d = ADDR;
        end
      end
      ADDR: state_d = WAIT;
      WAIT: begin
        buf_d   = rom_data;
        state_d = OUT;
      end
      OUT: begin
        if (row_ready) begin
          if (r_q < R_LAST) begin
            r_d     = r_q + 5'd1;
            state_d = ADDR;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        if (fc_q == FC_LAST) begin
          fc_d  = '0;
          off_d = off_step;
        end else begin
          fc_d = fc_q + FCW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      r_q     <= '0;
      buf_q   <= '0;
      off_q   <= '0;
      fc_q    <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      buf_q   <= buf_d;
      off_q   <= off_d;
      fc_q    <= fc_d;
    end
  end

  // Window column index wraps once at most, since offset+i < 2*COLS.
  logic [7:0] sum;
  logic [6:0] col;

  always_comb begin
    row_pix = '0;
    sum     = '0;
    col     = '0;
    for (int i = 0; i < WIN; i++) begin
      sum = {1'b0, off_q} + 8'(i);
      col = (sum >= 8'(COLS)) ? 7'(sum - 8'(COLS)) : sum[6:0];
      row_pix[WIN-1-i] = buf_q[C_LAST - col];
    end
  end

  assign rom_addr   = r_q;
  assign row_idx    = r_q;
  assign row_valid  = (state_q == OUT);
  assign frame_done = (state_q == DONE);
  assign busy       = (state_q != IDLE);
  assign offset     = off_q;

endmodule

// File: tb/tb_banner_scroll_ctrl.sv
// tb_banner_scroll_ctrl: directed bench for banner_scroll_ctrl with a
// registered ROM model; checks reset, rows, stalls, scrolling and abort.
module tb_banner_scroll_ctrl;

  logic        clk = 0;
  logic        rst = 0;
  logic        start = 0;
  logic [4:0]  rom_addr;
  logic [70:0] rom_data = '0;
  logic        row_valid;
  logic        row_ready = 0;
  logic [4:0]  row_idx;
  logic [15:0] row_pix;
  logic        frame_done;
  logic        busy;
  logic [6:0]  offset;
`ifdef BANNER_SCROLL_BIDIR_EN
  logic        dir = 0;
`endif

  int tests = 0;
  int fails = 0;

  logic [70:0] rom [15];
  logic [15:0] got_pix [15];

  banner_scroll_ctrl #(
    .ROWS(15), .COLS(71), .WIN(16), .SCROLL_DIV(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .rom_addr(rom_addr),
    .rom_data(rom_data),
    .row_valid(row_valid),
    .row_ready(row_ready),
    .row_idx(row_idx),
    .row_pix(row_pix),
    .frame_done(frame_done),
    .busy(busy),
    .offset(offset)
`ifdef BANNER_SCROLL_BIDIR_EN
    ,
    .dir(dir)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    rom_data <= (rom_addr < 5'd15) ? rom[rom_addr] : '0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] model(input int row, input int off);
    logic [15:0] m;
    logic [70:0] w;
    int c;
    w = rom[row];
    m = '0;
    for (int i = 0; i < 16; i++) begin
      c = (off + i) % 71;
      m[15-i] = w[70-c];
    end
    return m;
  endfunction

  task automatic run_frame(input bit ck, input int stall_row,
                           input bit poke, input bit sdone,
                           input int off, output int lat);
    int n;
    int rows;
    bit stalled;
    logic [15:0] p;
    logic [4:0] a;
    start = 1;
    row_ready = 1;
    step();
    start = 0;
    n = 1;
    rows = 0;
    stalled = 0;
    lat = -1;
    while (n < 300 && lat < 0) begin
      if (frame_done) begin
        lat = n;
      end else begin
        if (row_valid) begin
          if (int'(row_idx) == stall_row && !stalled) begin
            stalled = 1;
            row_ready = 0;
            p = row_pix;
            a = rom_addr;
            for (int k = 0; k < 10; k++) begin
              step();
              n++;
              chk("stall_valid", 32'(row_valid), 1);
              chk("stall_idx", 32'(row_idx), 32'(stall_row));
              chk("stall_pix", 32'(row_pix), 32'(p));
              chk("stall_addr", 32'(rom_addr), 32'(a));
            end
            row_ready = 1;
          end
          if (ck) begin
            chk("row_idx", 32'(row_idx), 32'(rows));
            chk("row_pix", 32'(row_pix), 32'(model(rows, off)));
            chk("busy_run", 32'(busy), 1);
          end
          if (rows < 15) got_pix[rows] = row_pix;
          rows++;
        end
        start = poke && row_valid && rows == 3;
        step();
        start = 0;
        n++;
      end
    end
    if (lat < 0) chk("frame_timeout", 0, 1);
    start = sdone;
    step();
    start = 0;
    chk("done_pulse", 32'(frame_done), 0);
    chk("idle_after", 32'(busy), 0);
    if (ck) chk("row_count", 32'(rows), 15);
  endtask

  initial begin
    int lat;
    int n;
    logic [71:0] t;
    for (int k = 0; k < 15; k++) begin
      t = {9{8'(k * 37 + 11)}};
      rom[k] = t[70:0];
    end
    rom[0][70:55] = 16'b1111100000011111;
    rom[0][0]     = 1'b1;
    rom[3][70:55] = 16'b1100011100011100;

    rst = 1;
    step();
    step();
    rst = 0;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_valid", 32'(row_valid), 0);
    chk("rst_done", 32'(frame_done), 0);
    chk("rst_offset", 32'(offset), 0);
    chk("rst_addr", 32'(rom_addr), 0);
    chk("rst_idx", 32'(row_idx), 0);
    chk("rst_pix", 32'(row_pix), 0);

    // Frame 1: full-rate transfers at offset 0.
    run_frame(1, -1, 0, 0, 0, lat);
    chk("latency", 32'(lat), 46);
    chk("row0_pix", 32'(got_pix[0]), 32'(16'b1111100000011111));
    chk("row3_pix", 32'(got_pix[3]), 32'(16'b1100011100011100));
    chk("off_f1", 32'(offset), 0);

    // Frame 2: stall row 5 for 10 cycles, start poked mid-frame.
    run_frame(1, 5, 1, 0, 0, lat);
    chk("latency_stall", 32'(lat), 56);

    // Frame 3: start held in the DONE cycle is ignored.
    run_frame(1, -1, 0, 1, 0, lat);
    chk("off_f3", 32'(offset), 0);

    for (int f = 4; f <= 284; f++) begin
      run_frame((f == 225 || f == 281), -1, 0, 0, ((f - 1) / 4) % 71, lat);
      chk("offset_step", 32'(offset), 32'((f / 4) % 71));
      if (f == 225)
        chk("off56_left", 32'(got_pix[0][15]), 32'(rom[0][14]));
      if (f == 281)
        chk("off70_wrap", 32'(got_pix[0]), 32'(16'b1111110000001111));
    end
    chk("offset_wrap0", 32'(offset), 0);

    for (int f = 0; f < 4; f++) run_frame(0, -1, 0, 0, 0, lat);
    chk("offset_one", 32'(offset), 1);

    // Abort mid-frame at row 7.
    start = 1;
    row_ready = 1;
    step();
    start = 0;
    n = 0;
    while (!(row_valid && row_idx == 5'd7) && n < 100) begin
      step();
      n++;
    end
    chk("reach_row7", 32'(n < 100), 1);
    rst = 1;
    step();
    rst = 0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_valid", 32'(row_valid), 0);
    chk("abort_offset", 32'(offset), 0);
    chk("abort_done", 32'(frame_done), 0);
    chk("abort_idx", 32'(row_idx), 0);
    step();
    chk("abort_done2", 32'(frame_done), 0);

    run_frame(1, -1, 0, 0, 0, lat);
    chk("restart_lat", 32'(lat), 46);
    chk("restart_row0", 32'(got_pix[0]), 32'(16'b1111100000011111));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/banner_scroll_ctrl.md
BANNER_SCROLL_CTRL -- requirements
Module: banner_scroll_ctrl

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
- ROWS, 15, banner rows.
- COLS, 71, banner columns (ROM word width).
- WIN, 16, visible window width in pixels.
- SCROLL_DIV, 4, frames per one-column scroll step (>=1).
REQ-002 Ports SHALL be, one per line as name, direction, width, meaning:
- clk  in  1  single clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  frame request pulse.
- rom_addr  out  5  banner ROM row address, registered.
- rom_data  in  COLS  ROM row data, valid the cycle after rom_addr is sampled.
- row_valid  out  1  row_pix/row_idx valid.
- row_ready  in  1  consumer accepts the row.
- row_idx  out  5  row number of the presented row.
- row_pix  out  WIN  windowed row pixels; MSB is the leftmost pixel.
- frame_done  out  1  one-cycle pulse after the last row is accepted.
- busy  out  1  high in any state except IDLE.
- offset  out  7  current scroll column, 0..COLS-1.

Function
REQ-003 FSM states SHALL be IDLE, ADDR, WAIT, OUT and DONE.
REQ-004 IDLE: start=1 SHALL set row counter r=0, drive rom_addr=0 and enter ADDR; start=0 SHALL hold IDLE.
REQ-005 ADDR SHALL last exactly one cycle while the ROM registers rom_addr, then go to WAIT.
REQ-006 WAIT SHALL capture rom_data into a COLS-bit row buffer at the cycle end, then go to OUT.
REQ-007 OUT SHALL assert row_valid with row_idx=r and row_pix from the row buffer, and SHALL hold both stable until row_ready=1.
REQ-008 Row transfer SHALL occur on a cycle with row_valid=1 and row_ready=1: if r<ROWS-1, set r=r+1, rom_addr=r+1 and go to ADDR; else go to DONE.
REQ-009 Minimum latency SHALL be 3 cycles per row (ADDR, WAIT, OUT) with row_ready tied high, giving 45 cycles from start to the last transfer.
REQ-010 Window mapping SHALL be row_pix[WIN-1-i] = buffer bit (COLS-1-c) with c=(offset+i) mod COLS, for i=0..WIN-1; columns wrap past COLS-1 to 0.
REQ-011 DONE SHALL pulse frame_done for one cycle, increment the frame counter and return to IDLE.
REQ-012 When the frame counter reaches SCROLL_DIV-1, it SHALL clear and offset SHALL advance by one column (COLS-1 wraps to 0).
REQ-013 offset SHALL change only in DONE, so offset is constant for every row of a frame.
REQ-014 start SHALL be ignored while busy=1, with no queueing; start asserted in the DONE cycle is also ignored.
REQ-015 row_ready while row_valid=0 SHALL have no effect.

Reset
REQ-016 rst=1 SHALL force, at the next posedge, state=IDLE, r=0, rom_addr=0, row_valid=0, frame_done=0, busy=0, offset=0, frame counter=0, row_pix=0 and row_idx=0.
REQ-017 rst asserted mid-frame SHALL abort the frame without a frame_done pulse; rst has priority over start and row_ready.

Configuration
REQ-018 Macro BANNER_SCROLL_BIDIR_EN SHALL behave as follows:
- Defined: adds input port dir (1 bit), sampled in DONE. dir=0 advances offset by +1 with wrap as in REQ-012; dir=1 steps it by -1, with 0 wrapping to COLS-1.
- Undefined: the dir port is absent and offset only increments.

Verification
REQ-019 Reset, then start with row_ready=1 and offset=0 -> row 0 row_pix=16'b1111100000011111; row 3 row_pix=16'b1100011100011100; frame_done pulses 46 cycles after start.
REQ-020 Hold row_ready=0 for 10 cycles on row 5 -> row_valid, row_idx=5 and row_pix stay stable; no rom_addr change; the frame then completes normally.
REQ-021 Run 4*71 frames with SCROLL_DIV=4 -> offset steps every 4th frame_done and returns to 0 after the 284th frame.
REQ-022 At offset=70, check row 0 -> row_pix=16'b1111110000001111 (wrap); at offset=56, check row 0 -> leftmost pixel is ROM bit 14.
REQ-023 Assert rst during row 7 of a frame -> next cycle busy=0, row_valid=0, offset=0, no frame_done; a subsequent start begins at row 0.
REQ-024 With BANNER_SCROLL_BIDIR_EN defined, dir=1, SCROLL_DIV=1 and offset=0 -> offset=70 after one frame and 69 after the next.
